// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared defines for the ysyx_22040237 instruction fetch unit:
// reset PC, NOP encoding and FSM state encodings.
package ysyx_22040237_ifu_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    // Instructions are word aligned, so the low two target bits are dropped.
    function automatic logic [63:0] alignPc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22040237_ifu_if.sv
// Instruction memory request/response bus between the IFU (master) and memory (slave).
interface ysyx_22040237_ifu_if;

    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        imem_resp_err_i;

    modport master (
        output imem_req_valid_o,
        output imem_addr_o,
        input  imem_req_ready_i,
        input  imem_resp_valid_i,
        input  imem_resp_data_i,
        input  imem_resp_err_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_addr_o,
        output imem_req_ready_i,
        output imem_resp_valid_i,
        output imem_resp_data_i,
        output imem_resp_err_i
    );

endinterface

// File: rtl/ysyx_22040237_ifu_pc.sv
// PC register with its next-PC mux: hold, sequential +4, or redirect target.
module ysyx_22040237_ifu_pc
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        advance_i,
    output logic [63:0] pc_o
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;

    // A redirect wins over a same-cycle advance; the add wraps modulo 2^64.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = alignPc(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding the decode stage,
// with redirect handling that discards responses of abandoned requests.
module ysyx_22040237_ifu
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22040237_ifu_if.master        imem,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    output logic [31:0]                inst_o,
    output logic [63:0]                pc_o,
    output logic                       inst_err_o,
    input  logic                       redirect_valid_i,
    input  logic [63:0]                redirect_pc_i
);

    ifu_state_e  state_q;
    ifu_state_e  state_d;
    logic        drop_q;
    logic        drop_d;
    logic        instValid_q;
    logic        instValid_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;
    logic [63:0] instPc_q;
    logic [63:0] instPc_d;
    logic        instErr_q;
    logic        instErr_d;

    logic [63:0] curPc;
    logic        advancePc;
    logic        reqFire;
    logic        instFire;

    assign reqFire  = (state_q == IFU_REQ) && imem.imem_req_ready_i;
    assign instFire = instValid_q && inst_ready_i;

    ysyx_22040237_ifu_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .advance_i        (advancePc),
        .pc_o             (curPc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IFU_IDLE;
            drop_q      <= 1'b0;
            instValid_q <= 1'b0;
            inst_q      <= NOP_INST;
            instPc_q    <= RESET_PC;
            instErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            instValid_q <= instValid_d;
            inst_q      <= inst_d;
            instPc_q    <= instPc_d;
            instErr_q   <= instErr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        instValid_d = instValid_q;
        inst_d      = inst_q;
        instPc_d    = instPc_q;
        instErr_d   = instErr_q;
        advancePc   = 1'b0;
        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_REQ;
            end
            IFU_REQ: begin
                if (reqFire) begin
                    state_d = IFU_WAIT;
                    drop_d  = redirect_valid_i;
                end
            end
            IFU_WAIT: begin
                // A response in the redirect cycle belongs to the old path and is
                // consumed here, so no drop is left pending for a later one.
                if (redirect_valid_i) begin
                    if (imem.imem_resp_valid_i) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem.imem_resp_valid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IFU_REQ;
                    end else begin
                        inst_d      = imem.imem_resp_data_i;
                        instErr_d   = imem.imem_resp_err_i;
                        instPc_d    = curPc;
                        instValid_d = 1'b1;
                        state_d     = IFU_HOLD;
                    end
                end
            end
            IFU_HOLD: begin
                if (redirect_valid_i) begin
                    instValid_d = 1'b0;
                    state_d     = IFU_REQ;
                end else if (instFire) begin
                    instValid_d = 1'b0;
                    advancePc   = 1'b1;
                    state_d     = IFU_REQ;
                end
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    always_comb begin
        imem.imem_req_valid_o = (state_q == IFU_REQ);
        imem.imem_addr_o      = curPc;
        inst_valid_o          = instValid_q;
        inst_o                = inst_q;
        pc_o                  = instPc_q;
        inst_err_o            = instErr_q;
    end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Scoreboard bench for ysyx_22040237_ifu: a latency-configurable memory model pushes
// expected instructions, and each decode-side consumption pops and compares one.
module tb_ysyx_22040237_ifu;
    import ysyx_22040237_ifu_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        inst_err_o;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;

    ysyx_22040237_ifu_if imemBus ();

    ysyx_22040237_ifu #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imemBus),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .inst_err_o       (inst_err_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checkCount = 0;
    int          passCount  = 0;
    int          hsCount    = 0;
    int          respLatency = 1;
    int          dropNext   = 0;
    logic [63:0] errAddr    = '1;
    bit          overrideValid = 1'b0;
    logic [31:0] overrideData  = 32'h0;

    exp_t        expQ[$];
    logic [63:0] pendAddr[$];
    int          pendTimer[$];

    function automatic logic [31:0] memData(input logic [63:0] addr);
        logic [31:0] low;
        low = addr[31:0];
        if (addr == 64'h8000_0000) return 32'h0010_0093;
        return low ^ 32'h5A5A_0013;
    endfunction

    // One clock: note acceptances/consumptions before the edge, drive memory responses after it.
    task automatic step();
        exp_t        e;
        logic [63:0] a;
        logic [31:0] d;
        logic        er;
        if (imemBus.imem_req_valid_o === 1'b1 && imemBus.imem_req_ready_i === 1'b1) begin
            pendAddr.push_back(imemBus.imem_addr_o);
            pendTimer.push_back(respLatency);
        end
        if (inst_valid_o === 1'b1 && (inst_ready_i === 1'b1 || redirect_valid_i === 1'b1)) begin
            hsCount++;
            checkCount++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL sb_empty: got pc %h inst %h, want no instruction presented", pc_o, inst_o);
            end else begin
                e = expQ.pop_front();
                if (inst_o !== e.inst || pc_o !== e.pc || inst_err_o !== e.err)
                    $display("[TB] FAIL sb_inst: got pc %h inst %h err %0b, want pc %h inst %h err %0b",
                             pc_o, inst_o, inst_err_o, e.pc, e.inst, e.err);
                else
                    passCount++;
            end
        end
        @(posedge clk);
        #1;
        imemBus.imem_resp_valid_i = 1'b0;
        imemBus.imem_resp_data_i  = 32'h0;
        imemBus.imem_resp_err_i   = 1'b0;
        foreach (pendTimer[i]) pendTimer[i]--;
        if (pendTimer.size() > 0 && pendTimer[0] <= 0) begin
            a = pendAddr.pop_front();
            void'(pendTimer.pop_front());
            d = overrideValid ? overrideData : memData(a);
            overrideValid = 1'b0;
            er = (a == errAddr);
            imemBus.imem_resp_valid_i = 1'b1;
            imemBus.imem_resp_data_i  = d;
            imemBus.imem_resp_err_i   = er;
            if (dropNext > 0) dropNext--;
            else expQ.push_back('{pc: a, inst: d, err: er});
        end
    endtask

    task automatic fetchOne(input string name);
        int start = hsCount;
        int n = 0;
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b1;
        while (hsCount == start && n < 20) begin
            step();
            n++;
        end
        imemBus.imem_req_ready_i = 1'b0;
        checkCount++;
        if (hsCount == start) $display("[TB] FAIL %s_timeout: got no handshake in %0d cycles, want one", name, n);
        else passCount++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = 64'h0;
        imemBus.imem_req_ready_i  = 1'b0;
        imemBus.imem_resp_valid_i = 1'b0;
        imemBus.imem_resp_data_i  = 32'h0;
        imemBus.imem_resp_err_i   = 1'b0;
        step();
        step();
        checkCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL rst_valid: got %0b want 0", inst_valid_o); else passCount++;
        checkCount++; if (inst_o !== NOP_INST) $display("[TB] FAIL rst_inst: got %h want %h", inst_o, NOP_INST); else passCount++;
        checkCount++; if (pc_o !== RST_PC) $display("[TB] FAIL rst_pc: got %h want %h", pc_o, RST_PC); else passCount++;
        checkCount++; if (inst_err_o !== 1'b0) $display("[TB] FAIL rst_err: got %0b want 0", inst_err_o); else passCount++;
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b0) $display("[TB] FAIL rst_req: got %0b want 0", imemBus.imem_req_valid_o); else passCount++;
        rst = 1'b0;
        #1;
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b0) $display("[TB] FAIL idle_req: got %0b want 0", imemBus.imem_req_valid_o); else passCount++;
        step();
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1) $display("[TB] FAIL first_req: got %0b want 1", imemBus.imem_req_valid_o); else passCount++;
        checkCount++; if (imemBus.imem_addr_o !== RST_PC) $display("[TB] FAIL first_addr: got %h want %h", imemBus.imem_addr_o, RST_PC); else passCount++;
    endtask

    task automatic test_basic();
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b1;
        step();
        step();
        checkCount++; if (inst_valid_o !== 1'b1) $display("[TB] FAIL basic_valid: got %0b want 1", inst_valid_o); else passCount++;
        checkCount++; if (inst_o !== 32'h0010_0093) $display("[TB] FAIL basic_inst: got %h want 00100093", inst_o); else passCount++;
        checkCount++; if (pc_o !== 64'h8000_0000) $display("[TB] FAIL basic_pc: got %h want 80000000", pc_o); else passCount++;
        step();
        imemBus.imem_req_ready_i = 1'b0;
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0004)
            $display("[TB] FAIL basic_next: got req %0b addr %h want req 1 addr 80000004", imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
    endtask

    task automatic test_stall();
        logic [63:0] pcExp = 64'h8000_0004;
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checkCount++;
            if (inst_valid_o !== 1'b1 || inst_o !== memData(pcExp) || pc_o !== pcExp || imemBus.imem_req_valid_o !== 1'b0)
                $display("[TB] FAIL stall_hold%0d: got valid %0b inst %h pc %h req %0b want 1 %h %h 0",
                         i, inst_valid_o, inst_o, pc_o, imemBus.imem_req_valid_o, memData(pcExp), pcExp);
            else passCount++;
        end
        inst_ready_i = 1'b1;
        step();
        imemBus.imem_req_ready_i = 1'b0;
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0008)
            $display("[TB] FAIL stall_next: got req %0b addr %h want req 1 addr 80000008", imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
    endtask

    task automatic test_redirect_req();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0050;
        step();
        redirect_valid_i = 1'b0;
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0050)
            $display("[TB] FAIL redir_req: got req %0b addr %h want req 1 addr 80000050", imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
        fetchOne("redir_req");
        checkCount++; if (imemBus.imem_addr_o !== 64'h8000_0054) $display("[TB] FAIL redir_req_next: got %h want 80000054", imemBus.imem_addr_o); else passCount++;
    endtask

    task automatic test_redirect_accept();
        imemBus.imem_req_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0080;
        dropNext = 1;
        step();
        redirect_valid_i = 1'b0;
        imemBus.imem_req_ready_i = 1'b0;
        step();
        checkCount++; if (inst_valid_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0080)
            $display("[TB] FAIL redir_acc: got valid %0b req %0b addr %h want 0 1 80000080", inst_valid_o, imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
        fetchOne("redir_acc");
    endtask

    task automatic test_redirect_wait();
        respLatency = 2;
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b1;
        step();
        imemBus.imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0100;
        overrideValid = 1'b1;
        overrideData = 32'hDEAD_BEEF;
        dropNext = 1;
        step();
        redirect_valid_i = 1'b0;
        checkCount++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL redir_wait_v1: got %0b want 0", inst_valid_o); else passCount++;
        step();
        respLatency = 1;
        checkCount++; if (inst_valid_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0100)
            $display("[TB] FAIL redir_wait: got valid %0b req %0b addr %h want 0 1 80000100", inst_valid_o, imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
        fetchOne("redir_wait");
        // Redirect landing in the same cycle as the response.
        imemBus.imem_req_ready_i = 1'b1;
        dropNext = 1;
        step();
        imemBus.imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0140;
        step();
        redirect_valid_i = 1'b0;
        checkCount++; if (inst_valid_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0140)
            $display("[TB] FAIL redir_same: got valid %0b req %0b addr %h want 0 1 80000140", inst_valid_o, imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
        fetchOne("redir_same");
    endtask

    task automatic test_redirect_hold();
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b0;
        step();
        step();
        imemBus.imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0203;
        inst_ready_i = 1'b1;
        step();
        redirect_valid_i = 1'b0;
        checkCount++; if (inst_valid_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h8000_0200)
            $display("[TB] FAIL redir_hold: got valid %0b req %0b addr %h want 0 1 80000200", inst_valid_o, imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
    endtask

    task automatic test_err();
        errAddr = 64'h8000_0200;
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b0;
        step();
        step();
        checkCount++; if (inst_valid_o !== 1'b1 || inst_err_o !== 1'b1 || inst_o !== memData(64'h8000_0200))
            $display("[TB] FAIL err_set: got valid %0b err %0b inst %h want 1 1 %h", inst_valid_o, inst_err_o, inst_o, memData(64'h8000_0200));
        else passCount++;
        inst_ready_i = 1'b1;
        step();
        inst_ready_i = 1'b0;
        step();
        step();
        checkCount++; if (inst_valid_o !== 1'b1 || inst_err_o !== 1'b0 || pc_o !== 64'h8000_0204)
            $display("[TB] FAIL err_clear: got valid %0b err %0b pc %h want 1 0 80000204", inst_valid_o, inst_err_o, pc_o);
        else passCount++;
        imemBus.imem_req_ready_i = 1'b0;
        inst_ready_i = 1'b1;
        step();
        errAddr = '1;
    endtask

    task automatic test_wrap();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid_i = 1'b0;
        checkCount++; if (imemBus.imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC) $display("[TB] FAIL wrap_addr: got %h want fffffffffffffffc", imemBus.imem_addr_o); else passCount++;
        fetchOne("wrap");
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== 64'h0)
            $display("[TB] FAIL wrap_next: got req %0b addr %h want 1 0", imemBus.imem_req_valid_o, imemBus.imem_addr_o);
        else passCount++;
    endtask

    task automatic test_reset_wait();
        respLatency = 3;
        dropNext = 1;
        imemBus.imem_req_ready_i = 1'b1;
        inst_ready_i = 1'b1;
        step();
        rst = 1'b1;
        imemBus.imem_req_ready_i = 1'b0;
        step();
        checkCount++; if (inst_valid_o !== 1'b0 || inst_o !== NOP_INST || pc_o !== RST_PC || inst_err_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b0)
            $display("[TB] FAIL rst_wait: got valid %0b inst %h pc %h err %0b req %0b want 0 %h %h 0 0",
                     inst_valid_o, inst_o, pc_o, inst_err_o, imemBus.imem_req_valid_o, NOP_INST, RST_PC);
        else passCount++;
        rst = 1'b0;
        step();
        checkCount++; if (imemBus.imem_req_valid_o !== 1'b1 || imemBus.imem_addr_o !== RST_PC)
            $display("[TB] FAIL rst_wait_req: got req %0b addr %h want 1 %h", imemBus.imem_req_valid_o, imemBus.imem_addr_o, RST_PC);
        else passCount++;
        step();
        respLatency = 1;
        checkCount++; if (inst_valid_o !== 1'b0 || imemBus.imem_req_valid_o !== 1'b1)
            $display("[TB] FAIL rst_stale: got valid %0b req %0b want 0 1", inst_valid_o, imemBus.imem_req_valid_o);
        else passCount++;
        fetchOne("rst_refetch");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test by %0t, want completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_req();
        test_redirect_accept();
        test_redirect_wait();
        test_redirect_hold();
        test_err();
        test_wrap();
        test_reset_wait();
        checkCount++; if (expQ.size() != 0) $display("[TB] FAIL sb_leftover: got %0d unconsumed instructions want 0", expQ.size()); else passCount++;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
